// File: rtl/frogger_game_sequencer.sv
// Frogger game-flow sequencer: frame-paced car stepping, lives, score and level tracking.
// The frame counter doubles as the PLAY car-step divider and the DEATH/LEVEL_UP hold timer.
module frogger_game_sequencer #(
  parameter int unsigned c_LIVES        = 3,
  parameter int unsigned c_BASE_PERIOD  = 30,
  parameter int unsigned c_PERIOD_STEP  = 3,
  parameter int unsigned c_MAX_LEVEL    = 7,
  parameter int unsigned c_DEATH_FRAMES = 60,
  parameter int unsigned c_LEVEL_FRAMES = 30,
  parameter int unsigned c_GOAL_ROW     = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_VSync,
  input  logic       i_Game_Start,
  input  logic       i_Collided,
  input  logic [5:0] i_Frogger_Y,
  output logic [2:0] o_State,
  output logic       o_Frog_Reset,
  output logic       o_Car_Enable,
  output logic       o_Car_Step,
  output logic [2:0] o_Level,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Score
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0]       LIVES_INIT  = 2'(c_LIVES);
  localparam logic [2:0]       LEVEL_MAX   = 3'(c_MAX_LEVEL);
  localparam logic [5:0]       GOAL_ROW    = 6'(c_GOAL_ROW);
  localparam logic [6:0]       SCORE_MAX   = 7'd99;
  localparam logic [CNT_W-1:0] BASE_PER    = CNT_W'(c_BASE_PERIOD);
  localparam logic [CNT_W-1:0] DEATH_LAST  = CNT_W'(c_DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] LEVEL_LAST  = CNT_W'(c_LEVEL_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DEATH     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_vsync_d, r_start_d;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic             r_armed, w_armed_nxt;
  logic [2:0]       r_level, w_level_nxt;
  logic [1:0]       r_lives, w_lives_nxt;
  logic [6:0]       r_score, w_score_nxt;
  logic             r_frog_reset, w_frog_reset_nxt;
  logic             r_car_enable, w_car_enable_nxt;
  logic             r_car_step, w_car_step_nxt;
  logic             w_tick, w_start;
  logic [CNT_W-1:0] w_period_dec, w_period;

  assign w_tick  = i_VSync & ~r_vsync_d;
  assign w_start = i_Game_Start & ~r_start_d;

  // Car-step period shrinks with level, floored at one frame instead of wrapping
  assign w_period_dec = CNT_W'(c_PERIOD_STEP) * CNT_W'(r_level);
  assign w_period     = (w_period_dec >= BASE_PER) ? CNT_W'(1) : (BASE_PER - w_period_dec);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state      <= ST_IDLE;
      r_vsync_d    <= 1'b0;
      r_start_d    <= 1'b0;
      r_frame_cnt  <= '0;
      r_armed      <= 1'b0;
      r_level      <= '0;
      r_lives      <= LIVES_INIT;
      r_score      <= '0;
      r_frog_reset <= 1'b0;
      r_car_enable <= 1'b0;
      r_car_step   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vsync_d    <= i_VSync;
      r_start_d    <= i_Game_Start;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_armed      <= w_armed_nxt;
      r_level      <= w_level_nxt;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_frog_reset <= w_frog_reset_nxt;
      r_car_enable <= w_car_enable_nxt;
      r_car_step   <= w_car_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_armed_nxt      = r_armed;
    w_level_nxt      = r_level;
    w_lives_nxt      = r_lives;
    w_score_nxt      = r_score;
    w_car_step_nxt   = 1'b0;
    w_frog_reset_nxt = 1'b0;
    w_car_enable_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_lives_nxt = LIVES_INIT;
        w_score_nxt = '0;
        w_level_nxt = '0;
        if (w_start) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // Collision outranks goal; neither is looked at until the first tick after entry
        if (r_armed && i_Collided) begin
          if (r_lives != 2'd0) w_lives_nxt = r_lives - 2'd1;
          w_state_nxt = ST_DEATH;
        end else if (r_armed && (i_Frogger_Y == GOAL_ROW)) begin
          if (r_score < SCORE_MAX) w_score_nxt = r_score + 7'd1;
          if (r_level < LEVEL_MAX) w_level_nxt = r_level + 3'd1;
          w_state_nxt = ST_LEVEL_UP;
        end else if (w_tick) begin
          w_armed_nxt = 1'b1;
          if (r_frame_cnt >= (w_period - CNT_W'(1))) begin
            w_car_step_nxt  = 1'b1;
            w_frame_cnt_nxt = '0;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      ST_DEATH: begin
        if (w_tick) begin
          if (r_frame_cnt >= DEATH_LAST)
            w_state_nxt = (r_lives == 2'd0) ? ST_GAME_OVER : ST_PLAY;
          else
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end
      end
      ST_LEVEL_UP: begin
        if (w_tick) begin
          if (r_frame_cnt >= LEVEL_LAST) w_state_nxt = ST_PLAY;
          else                           w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end
      end
      ST_GAME_OVER: begin
        if (w_start) begin
          w_lives_nxt = LIVES_INIT;
          w_score_nxt = '0;
          w_level_nxt = '0;
          w_state_nxt = ST_PLAY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt != r_state) begin
      w_frame_cnt_nxt = '0;
      w_armed_nxt     = 1'b0;
    end
    w_frog_reset_nxt = (w_state_nxt == ST_PLAY) && (r_state != ST_PLAY);
    w_car_enable_nxt = (w_state_nxt == ST_PLAY);
  end

  assign o_State      = r_state;
  assign o_Frog_Reset = r_frog_reset;
  assign o_Car_Enable = r_car_enable;
  assign o_Car_Step   = r_car_step;
  assign o_Level      = r_level;
  assign o_Lives      = r_lives;
  assign o_Score      = r_score;

endmodule

// File: tb/tb_frogger_game_sequencer.sv
// Directed bench for frogger_game_sequencer with short periods and hold times.
// Output vector layout: {state[3], frog_reset, car_enable, car_step, level[3], lives[2], score[7]}.
module tb_frogger_game_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_VSync = 1'b0;
  logic       i_Game_Start = 1'b0;
  logic       i_Collided = 1'b0;
  logic [5:0] i_Frogger_Y = 6'd20;
  logic [2:0] o_State;
  logic       o_Frog_Reset, o_Car_Enable, o_Car_Step;
  logic [2:0] o_Level;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  frogger_game_sequencer #(
    .c_LIVES(2), .c_BASE_PERIOD(4), .c_PERIOD_STEP(1), .c_MAX_LEVEL(7),
    .c_DEATH_FRAMES(2), .c_LEVEL_FRAMES(2), .c_GOAL_ROW(0)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_VSync(i_VSync), .i_Game_Start(i_Game_Start),
    .i_Collided(i_Collided), .i_Frogger_Y(i_Frogger_Y), .o_State(o_State),
    .o_Frog_Reset(o_Frog_Reset), .o_Car_Enable(o_Car_Enable), .o_Car_Step(o_Car_Step),
    .o_Level(o_Level), .o_Lives(o_Lives), .o_Score(o_Score)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) if (o_Car_Step === 1'b1) pulse_cnt = pulse_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [18:0] outs();
    return {o_State, o_Frog_Reset, o_Car_Enable, o_Car_Step, o_Level, o_Lives, o_Score};
  endfunction

  // One idle frame cycle then one VSync rising edge; returns just after the tick edge
  task automatic do_tick();
    @(negedge i_Clk); i_VSync = 1'b1;
    @(negedge i_Clk); i_VSync = 1'b0;
  endtask

  task automatic pulse_start();
    i_Game_Start = 1'b1;
    @(negedge i_Clk); i_Game_Start = 1'b0;
  endtask

  // From a fresh PLAY entry: arm, score a goal, sit out LEVEL_UP, back to PLAY
  task automatic do_goal();
    do_tick();
    i_Frogger_Y = 6'd0;
    @(negedge i_Clk); i_Frogger_Y = 6'd20;
    do_tick();
    do_tick();
  endtask

  task automatic test_reset();
    logic [18:0] exp;
    i_Rst = 1'b1;
    @(negedge i_Clk);
    exp = {3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 7'd0};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL reset_values got %h want %h", outs(), exp); end
    i_Rst = 1'b0;
    @(negedge i_Clk);
    checks++; if (outs() !== exp) begin errors++; $display("FAIL idle_hold got %h want %h", outs(), exp); end
  endtask

  task automatic test_start();
    logic [18:0] exp;
    pulse_start();
    exp = {3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd2, 7'd0};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL start_entry got %h want %h", outs(), exp); end
    @(negedge i_Clk);
    exp = {3'd1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 7'd0};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL frog_reset_width got %h want %h", outs(), exp); end
  endtask

  task automatic test_car_step();
    pulse_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      checks++;
      if (o_Car_Step !== ((i == 3) || (i == 7))) begin
        errors++; $display("FAIL car_step_tick%0d got %b want %b", i + 1, o_Car_Step, (i == 3) || (i == 7));
      end
    end
    @(negedge i_Clk);
    checks++; if (o_Car_Step !== 1'b0) begin errors++; $display("FAIL car_step_width got %b want 0", o_Car_Step); end
    checks++; if (pulse_cnt !== 2) begin errors++; $display("FAIL car_step_count got %0d want 2", pulse_cnt); end
  endtask

  task automatic test_goal();
    logic [18:0] exp;
    i_Frogger_Y = 6'd0;
    @(negedge i_Clk); i_Frogger_Y = 6'd20;
    exp = {3'd3, 1'b0, 1'b0, 1'b0, 3'd1, 2'd2, 7'd1};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL goal_level_up got %h want %h", outs(), exp); end
    do_tick();
    checks++; if (outs() !== exp) begin errors++; $display("FAIL level_up_hold got %h want %h", outs(), exp); end
    do_tick();
    exp = {3'd1, 1'b1, 1'b1, 1'b0, 3'd1, 2'd2, 7'd1};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL level_up_exit got %h want %h", outs(), exp); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++;
      if (o_Car_Step !== (i == 2)) begin
        errors++; $display("FAIL period3_tick%0d got %b want %b", i + 1, o_Car_Step, i == 2);
      end
    end
  endtask

  task automatic test_collision();
    logic [18:0] exp;
    i_Collided = 1'b1; i_Frogger_Y = 6'd0;
    @(negedge i_Clk); i_Collided = 1'b0; i_Frogger_Y = 6'd20;
    exp = {3'd2, 1'b0, 1'b0, 1'b0, 3'd1, 2'd1, 7'd1};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL collide_beats_goal got %h want %h", outs(), exp); end
    do_tick();
    checks++; if (outs() !== exp) begin errors++; $display("FAIL death_hold got %h want %h", outs(), exp); end
    do_tick();
    exp = {3'd1, 1'b1, 1'b1, 1'b0, 3'd1, 2'd1, 7'd1};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL death_to_play got %h want %h", outs(), exp); end
    do_tick();
    pulse_start();
    exp = {3'd1, 1'b0, 1'b1, 1'b0, 3'd1, 2'd1, 7'd1};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL start_ignored_play got %h want %h", outs(), exp); end
    i_Collided = 1'b1;
    @(negedge i_Clk); i_Collided = 1'b0;
    exp = {3'd2, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 7'd1};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL second_death got %h want %h", outs(), exp); end
    pulse_start();
    checks++; if (outs() !== exp) begin errors++; $display("FAIL start_ignored_death got %h want %h", outs(), exp); end
    do_tick();
    do_tick();
    exp = {3'd4, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 7'd1};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL game_over got %h want %h", outs(), exp); end
    i_Collided = 1'b1;
    @(negedge i_Clk); i_Collided = 1'b0;
    checks++; if (outs() !== exp) begin errors++; $display("FAIL collide_ignored_over got %h want %h", outs(), exp); end
  endtask

  task automatic test_restart_unarmed();
    logic [18:0] exp;
    pulse_start();
    exp = {3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd2, 7'd0};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL restart got %h want %h", outs(), exp); end
    i_Collided = 1'b1; i_Frogger_Y = 6'd0;
    @(negedge i_Clk); i_Collided = 1'b0; i_Frogger_Y = 6'd20;
    exp = {3'd1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 7'd0};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL unarmed_ignore got %h want %h", outs(), exp); end
  endtask

  task automatic test_level_clamp();
    logic [18:0] exp;
    repeat (7) do_goal();
    exp = {3'd1, 1'b1, 1'b1, 1'b0, 3'd7, 2'd2, 7'd7};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL level7 got %h want %h", outs(), exp); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++; if (o_Car_Step !== 1'b1) begin errors++; $display("FAIL clamp_tick%0d got %b want 1", i + 1, o_Car_Step); end
    end
    i_Frogger_Y = 6'd0;
    @(negedge i_Clk); i_Frogger_Y = 6'd20;
    exp = {3'd3, 1'b0, 1'b0, 1'b0, 3'd7, 2'd2, 7'd8};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL level_ceiling got %h want %h", outs(), exp); end
    do_tick();
    do_tick();
  endtask

  task automatic test_score_sat();
    logic [18:0] exp;
    repeat (91) do_goal();
    exp = {3'd1, 1'b1, 1'b1, 1'b0, 3'd7, 2'd2, 7'd99};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL score99 got %h want %h", outs(), exp); end
    do_goal();
    checks++; if (outs() !== exp) begin errors++; $display("FAIL score_saturate got %h want %h", outs(), exp); end
  endtask

  task automatic test_reset_mid_death();
    logic [18:0] exp;
    do_tick();
    i_Collided = 1'b1;
    @(negedge i_Clk); i_Collided = 1'b0;
    do_tick();
    exp = {3'd2, 1'b0, 1'b0, 1'b0, 3'd7, 2'd1, 7'd99};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL pre_reset_death got %h want %h", outs(), exp); end
    i_Rst = 1'b1; i_Game_Start = 1'b1;
    @(negedge i_Clk);
    exp = {3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 7'd0};
    checks++; if (outs() !== exp) begin errors++; $display("FAIL reset_mid_death got %h want %h", outs(), exp); end
    i_Rst = 1'b0; i_Game_Start = 1'b0;
    @(negedge i_Clk);
    checks++; if (outs() !== exp) begin errors++; $display("FAIL start_lost_in_reset got %h want %h", outs(), exp); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_car_step();
    test_goal();
    test_collision();
    test_restart_unarmed();
    test_level_clamp();
    test_score_sat();
    test_reset_mid_death();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frogger_game_sequencer.md
FROGGER_GAME_SEQUENCER -- requirements
Module: frogger_game_sequencer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- c_LIVES, 3: lives at game start (1..3).
- c_BASE_PERIOD, 30: frames per car step at level 0.
- c_PERIOD_STEP, 3: frames removed from the car-step period per level.
- c_MAX_LEVEL, 7: level ceiling.
- c_DEATH_FRAMES, 60: frames held in DEATH.
- c_LEVEL_FRAMES, 30: frames held in LEVEL_UP.
- c_GOAL_ROW, 0: frog row that scores.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- i_Clk, in, 1: single clock.
- i_Rst, in, 1: reset, synchronous, active-high.
- i_VSync, in, 1: frame sync.
- i_Game_Start, in, 1: debounced start button level.
- i_Collided, in, 1: frog/car overlap flag.
- i_Frogger_Y, in, 6: frog tile row.
- o_State, out, 3: FSM state.
- o_Frog_Reset, out, 1: one-cycle pulse that returns the frog to its start tile.
- o_Car_Enable, out, 1: car motion allowed.
- o_Car_Step, out, 1: one-cycle car advance pulse.
- o_Level, out, 3: current level.
- o_Lives, out, 2: remaining lives.
- o_Score, out, 7: score, 0..99.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 The frame tick SHALL be a single-cycle internal strobe, asserted in the cycle where i_VSync=1 and its registered previous sample=0.

REQ-005 The start edge SHALL be the cycle where i_Game_Start=1 and its registered previous sample=0.

REQ-006 The state encoding SHALL be IDLE=0, PLAY=1, DEATH=2, LEVEL_UP=3, GAME_OVER=4; other codes SHALL go to IDLE on the next cycle.

REQ-007 IDLE: o_Car_Enable=0, lives=c_LIVES, score=0, level=0. A start edge SHALL transition to PLAY.

REQ-008 Every entry into PLAY SHALL pulse o_Frog_Reset for exactly one cycle, on the cycle o_State first reads 1.

REQ-009 PLAY: o_Car_Enable=1. A frame counter SHALL count frame ticks. When it reaches period-1 on a tick, o_Car_Step SHALL be high in the next cycle and the counter SHALL clear.

REQ-010 The period SHALL equal c_BASE_PERIOD - c_PERIOD_STEP*level, computed at 8-bit width and clamped to a minimum of 1 (no underflow).

REQ-011 PLAY SHALL be disarmed on entry and become armed at the first frame tick after entry. Collision and goal checks SHALL occur only while armed, so a stale i_Frogger_Y or i_Collided right after a frog reset is ignored.

REQ-012 If armed and i_Collided=1: lives decrements by 1, next state is DEATH.

REQ-013 Else if armed and i_Frogger_Y==c_GOAL_ROW: score increments, saturating at 99; level increments unless already at c_MAX_LEVEL; next state is LEVEL_UP.

REQ-014 If collision and goal occur in the same cycle, collision SHALL win and score/level SHALL be unchanged.

REQ-015 A start edge in PLAY, DEATH or LEVEL_UP SHALL be ignored.

REQ-016 DEATH: o_Car_Enable=0. After c_DEATH_FRAMES frame ticks, the next state SHALL be GAME_OVER if lives==0, else PLAY.

REQ-017 LEVEL_UP: o_Car_Enable=0. After c_LEVEL_FRAMES frame ticks, the next state SHALL be PLAY.

REQ-018 i_Collided SHALL be ignored in DEATH, LEVEL_UP, IDLE and GAME_OVER.

REQ-019 GAME_OVER: o_Car_Enable=0; score and level held. A start edge SHALL reload lives=c_LIVES, score=0, level=0 and go to PLAY.

REQ-020 The frame counter SHALL clear on every state transition.

REQ-021 o_Car_Step SHALL be 0 in every state except PLAY.

Reset
REQ-022 With i_Rst=1 at a clock edge, the next cycle SHALL have: o_State=0, o_Frog_Reset=0, o_Car_Enable=0, o_Car_Step=0, o_Level=0, o_Lives=c_LIVES, o_Score=0, counters=0, armed=0, edge-detect registers=0.

REQ-023 Reset SHALL take priority over all other inputs in any state, including mid-countdown. A start edge coincident with reset SHALL be lost.

Verification
(Parameters for all scenarios: c_BASE_PERIOD=4, c_PERIOD_STEP=1, c_DEATH_FRAMES=2, c_LEVEL_FRAMES=2, c_LIVES=2.)

REQ-024 Scenario 1: reset, then start edge -> o_State=1; o_Frog_Reset high for 1 cycle; o_Lives=2, o_Score=0, o_Level=0.

REQ-025 Scenario 2: in PLAY at level 0, apply 8 frame ticks -> exactly 2 o_Car_Step pulses, each 1 cycle after the 4th and 8th ticks.

REQ-026 Scenario 3: after arming, i_Frogger_Y=0 -> LEVEL_UP, o_Score=1, o_Level=1. After 2 ticks -> PLAY with a frog reset pulse; the car-step period is now 3 ticks.

REQ-027 Scenario 4: i_Collided=1 and i_Frogger_Y=0 in the same armed cycle -> DEATH, o_Lives=1, o_Score unchanged. A second death -> o_Lives=0 -> after 2 ticks, o_State=4.

REQ-028 Scenario 5: i_Collided=1 in the cycle immediately after PLAY entry (not armed) -> no state change. At level 7, the period clamps to 1 and o_Car_Step fires every tick. Score at 99 plus a goal -> score stays 99.

REQ-029 Scenario 6: assert i_Rst during DEATH mid-countdown -> all REQ-022 values next cycle. In GAME_OVER, a start edge -> PLAY with o_Lives=2, o_Score=0.
